// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_pkg
//  Purpose  : Shared op encodings, FSM state type and operation decode
//             helpers for the iterative RV32M multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package mul_div_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Every divide/remainder op has funct3[2] set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV)  || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_if
//  Purpose  : Request/response bundle between the execute stage and the
//             multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_div_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    // Execute-stage side issues requests and observes the result
    modport master (output start, output op, output A, output B,
                    input  busy,  input  done, input  res);

    // Unit side
    modport slave  (input  start, input  op, input  A, input  B,
                    output busy,  output done, output res);
endinterface
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step: shift in the next
//             dividend bit, trial-subtract the divisor, keep or restore.
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH:0]   rem_i,
    input  wire logic             dividend_bit_i,
    input  wire logic [WIDTH-1:0] divisor_i,
    output logic      [WIDTH:0]   rem_o,
    output logic                  q_bit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtract one bit wider than the remainder so the borrow survives
    always_comb begin
        shifted = {rem_i, dividend_bit_i};
        diff    = shifted - {2'b00, divisor_i};
        q_bit_o = ~diff[WIDTH+1];
        rem_o   = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    end
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative RV32M multiply/divide. Shift-add multiply and
//             restoring divide on operand magnitudes, one bit per cycle,
//             with sign fix-up applied on the final iteration.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mul_div_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2:0]         op_q,      op_d;
    logic               neg_res_q, neg_res_d;   // product/quotient sign
    logic               neg_rem_q, neg_rem_d;   // remainder follows sign of A
    logic [WIDTH-1:0]   opnd_q,    opnd_d;      // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q,     acc_d;       // product, or dividend/quotient in low half
    logic [WIDTH:0]     rem_q,     rem_d;
    logic [WIDTH-1:0]   res_q,     res_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sgn_a, sgn_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next, prod_fix;
    logic [WIDTH:0]     div_rem_next;
    logic               div_q_bit;
    logic [WIDTH-1:0]   quo_next, quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i          (rem_q),
        .dividend_bit_i (acc_q[WIDTH-1]),
        .divisor_i      (opnd_q),
        .rem_o          (div_rem_next),
        .q_bit_o        (div_q_bit)
    );

    // Operand magnitudes, one iteration of each datapath, and signed results
    always_comb begin
        sgn_a        = is_signed_a(bus.op) & bus.A[WIDTH-1];
        sgn_b        = is_signed_b(bus.op) & bus.B[WIDTH-1];
        mag_a        = sgn_a ? -bus.A : bus.A;
        mag_b        = sgn_b ? -bus.B : bus.B;
        mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        quo_next     = {acc_q[WIDTH-2:0], div_q_bit};
        prod_fix     = neg_res_q ? -mul_acc_next : mul_acc_next;
        quo_fix      = neg_res_q ? -quo_next : quo_next;
        rem_fix      = neg_rem_q ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
    end

    // Next-state, datapath update and registered output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        res_d     = res_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                if (bus.start) begin
                    op_d      = bus.op;
                    cnt_d     = '0;
                    rem_d     = '0;
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    opnd_d    = is_div(bus.op) ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, (is_div(bus.op) ? mag_a : mag_b)};
                    if (is_div(bus.op) && (bus.B == '0)) begin
                        // Divide by zero: quotient all-ones, remainder is the dividend
                        res_d   = bus.op[1] ? bus.A : '1;
                        state_d = MD_DONE;
                        done_d  = 1'b1;
                    end else if (is_div(bus.op) && is_signed_b(bus.op) &&
                                 (bus.A == INT_MIN) && (bus.B == '1)) begin
                        // Signed overflow: quotient wraps to INT_MIN, remainder 0
                        res_d   = bus.op[1] ? '0 : INT_MIN;
                        state_d = MD_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = MD_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div(op_q)) begin
                    acc_d[WIDTH-1:0] = quo_next;
                    rem_d            = div_rem_next;
                end else begin
                    acc_d = mul_acc_next;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = MD_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    case (op_q)
                        MD_MUL:                       res_d = prod_fix[WIDTH-1:0];
                        MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod_fix[2*WIDTH-1:WIDTH];
                        MD_DIV, MD_DIVU:              res_d = quo_fix;
                        default:                      res_d = rem_fix;
                    endcase
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed vector bench for mul_div_unit: result, latency and
//             busy length per op, plus back-to-back, mid-CALC start and
//             mid-operation reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;
    import mul_div_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[18];

    mul_div_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Call just after the accepting edge. lat counts edges from the accepting
    // edge (=1) until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int bcnt, output logic overlap);
        lat = -1; bcnt = 0; overlap = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) bcnt++;
            @(posedge clk);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        int   lat, bcnt;
        logic ovl, seen;
        n_checks = 0; n_fail = 0;
        bus.start = 1'b0; bus.op = 3'b000; bus.A = '0; bus.B = '0;

        vecs[0]  = '{"mul_7_m3",        MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{"mulh_m1_m1",      MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[2]  = '{"mulhu_max_max",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{"mulhsu_m1_max",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{"div_m7_2",        MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{"rem_m7_2",        MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{"divu_100_7",      MD_DIVU,   32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{"remu_100_7",      MD_REMU,   32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{"div_by_zero",     MD_DIV,    32'd123,      32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"remu_by_zero",    MD_REMU,   32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"div_overflow",    MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"rem_overflow",    MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{"mul_big",         MD_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33};
        vecs[13] = '{"mulh_min_2",      MD_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, 33};
        vecs[14] = '{"div_7_m2",        MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[15] = '{"rem_7_m2",        MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vecs[16] = '{"divu_by_zero",    MD_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1};
        vecs[17] = '{"divu_max_1",      MD_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_res",  bus.res, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt, ovl);
            check({vecs[i].name, "_res"},  bus.res, vecs[i].exp);
            check({vecs[i].name, "_lat"},  lat, vecs[i].lat);
            check({vecs[i].name, "_busy"}, bcnt, (vecs[i].lat == 1) ? 0 : 32);
            check({vecs[i].name, "_ovl"},  {31'd0, ovl}, 32'd0);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            check({vecs[i].name, "_res_held"},   bus.res, vecs[i].exp);
        end

        // Back-to-back: start held high; new operands during CALC are ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MUL; bus.A = 32'd6; bus.B = 32'd7;
        @(posedge clk);
        #1 bus.op = MD_DIVU; bus.A = 32'd100; bus.B = 32'd7;
        wait_done(lat, bcnt, ovl);
        check("b2b_first_res", bus.res, 32'd42);
        check("b2b_first_lat", lat, 33);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, bcnt, ovl);
        check("b2b_second_res", bus.res, 32'd14);
        check("b2b_second_lat", lat, 33);

        // start pulsed mid-CALC is ignored
        issue(MD_MULHU, 32'h00010000, 32'h00010000);
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b1; bus.op = MD_MUL; bus.A = 32'd3; bus.B = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt, ovl);
        check("midstart_res", bus.res, 32'd1);
        check("midstart_lat", lat, 27);
        @(negedge clk);
        check("midstart_no_restart", {31'd0, bus.busy}, 32'd0);

        // Reset at CALC cycle 10 discards the operation
        issue(MD_DIVU, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_res",  bus.res, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("midrst_quiet", {31'd0, seen}, 32'd0);
        issue(MD_DIVU, 32'd1000, 32'd10);
        wait_done(lat, bcnt, ovl);
        check("after_rst_res", bus.res, 32'd100);
        check("after_rst_lat", lat, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit, sitting in the execute stage beside the ALU. It takes the same register-file operand buses (A, B) and drives a second result input of the writeback mux. Operations take multiple cycles, so the unit drives `busy` to stall the PC and register-file write-enable until the result is ready.

## Interface
- `WIDTH`, 32: operand/result width; iteration count equals WIDTH.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE or DONE.
- `op` input 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A` input WIDTH: rs1 operand. Captured on the accepting edge.
- `B` input WIDTH: rs2 operand. Captured on the accepting edge.
- `busy` output 1: high in CALC; the CPU holds PC and register-file write while it is high.
- `done` output 1: single-cycle pulse in DONE; `res` is valid in that cycle.
- `res` output WIDTH: result. Held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- **Accept.** `start=1` in IDLE or DONE accepts a request. On that edge the unit latches op, A and B, and clears the iteration counter.
  - Multiply operands and divide operands: store the magnitude and sign for each signed operand. Signed operands are A/B for MULH, DIV and REM, and A only for MULHSU.
  - Next state: CALC, except for the divide special cases below.
- **Divide special cases** resolve on the accepting edge: no CALC, next state DONE, result latched directly.
  - Divisor 0, DIV/DIVU: result all-ones.
  - Divisor 0, REM/REMU: result is A.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- **Multiply.** Shift-add, one bit of the multiplier per CALC cycle, into a 2·WIDTH accumulator.
- **Divide.** Restoring division, one quotient bit per CALC cycle. Remainder is WIDTH+1 bits wide so the trial subtract keeps its borrow.
- **Finish.** When counter = WIDTH−1, the iteration on that edge is the last one. On the same edge the unit applies the sign fix and latches `res`:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of A.
  - MUL selects the low WIDTH bits of the product; MULH, MULHSU and MULHU select the high WIDTH bits.
  - Next state: DONE.
- **DONE.** `done=1`. With `start=1` the unit accepts a new request (back-to-back). With `start=0` it returns to IDLE, and `res` is held.
- `start` during CALC is ignored. The operation in flight is unaffected.
- `op`, `A` and `B` are don't-care outside the accepting edge.

## Timing
- **Reset.** Asserting `rst_n` low at any time, including mid-CALC, forces IDLE, `busy=0`, `done=0`, `res=0` and counter 0. No done pulse follows, and the partial result is discarded.
- **Normal latency.** Start is sampled on edge E0. `busy` is high in cycles E0..E(WIDTH). `done` is high in cycle E(WIDTH)+1, i.e. the cycle after the WIDTH-th CALC edge. Total latency is WIDTH+1 edges: 33 for WIDTH=32.
- **Special-case latency.** `done` is high in the cycle right after E0, and `busy` never rises.
- `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mul_div_pkg`:
  - op encodings (`MD_MUL` … `MD_REMU`);
  - state enum (`MD_IDLE`, `MD_CALC`, `MD_DONE`);
  - the `is_div` and `is_signed_a`/`is_signed_b` decode helper functions.
- Sub-module `div_step`: purely combinational single restoring-division step. Inputs are the remainder, dividend bit and divisor; outputs are the next remainder and the quotient bit. It is instantiated once.
- Everything else lives in `mul_div_unit`: FSM, counter, accumulator and sign handling.

## Test plan
- MUL with A=7, B=−3 (0xFFFFFFFD) → `res`=0xFFFFFFEB, `done` exactly 33 cycles after start, `busy` high for exactly 32 cycles.
- MULH and MULHU with A=B=0xFFFFFFFF → MULH gives 0x00000000, MULHU gives 0xFFFFFFFE. MULHSU with A=−1, B=0xFFFFFFFF → 0xFFFFFFFF.
- DIV and REM with A=−7, B=2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIVU with A=100, B=7 → 14; REMU → 2.
- Special cases:
  - DIV with B=0 → 0xFFFFFFFF; REMU with A=5, B=0 → 5.
  - DIV with A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0.
  - Each has `done` 1 cycle after start and `busy` never asserted.
- Back-to-back and in-flight `start`:
  - `start` held high through DONE → the second op is accepted and `done` pulses again 33 cycles later.
  - `start` pulsed mid-CALC → ignored; the first result is unchanged.
- Reset mid-operation: `rst_n` low at CALC cycle 10 → `busy`, `done` and `res` go to 0 immediately with no done pulse. The next start completes normally with a correct result.
